fetch_prefetch_unit: RTL

//  Next-generation instruction fetch stage. Owns the fetch PC and issues held

---
 rtl/fetch_prefetch_unit.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues held memory requests and buffers
// {pc, instruction} pairs in a DEPTH-entry FIFO toward decode. Optional macro: FETCH_BYPASS_EN.
module fetch_prefetch_unit #(
   parameter int unsigned          XLEN     = 32,
   parameter int unsigned          DEPTH    = 4,
   parameter logic [XLEN-1:0]      RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic            valid,
   input  logic [XLEN-1:0] instruction,
   input  logic            Branch,
   input  logic            Jal,
   input  logic            Jalr,
   input  logic [XLEN-1:0] res_o,
   input  logic            instr_ready,
   output logic            mem_request,
   output logic [XLEN-1:0] mem_addr,
   output logic            we_re,
   output logic [3:0]      mask,
   output logic            instr_valid,
   output logic [XLEN-1:0] instr_out,
   output logic [XLEN-1:0] instr_pc,
   output logic [XLEN-1:0] pre_address
);

   localparam int unsigned     AW    = $clog2(DEPTH);
   localparam logic [AW:0]     FULL  = (AW+1)'(DEPTH);
   localparam logic [XLEN-1:0] FOUR  = XLEN'(4);
   localparam logic [XLEN-1:0] ALIGN = XLEN'(3);

   typedef enum logic [1:0] {IDLE, BUSY, DISCARD} state_t;

   state_t          state;
   logic [XLEN-1:0] pc;
   logic [AW:0]     count;
   logic [AW:0]     count_next;
   logic [AW-1:0]   rd_ptr;
   logic [AW-1:0]   wr_ptr;
   logic [XLEN-1:0] pc_mem  [DEPTH];
   logic [XLEN-1:0] ins_mem [DEPTH];

   logic            redirect;
   logic [XLEN-1:0] target;
   logic            fifo_nonempty;
   logic            bypass;
   logic            push;
   logic            pop;
   logic            accept;

   assign we_re = 1'b0;
   assign mask  = 4'b1111;

   always_comb begin
      redirect      = Branch | Jal | Jalr;
      target        = res_o & ~ALIGN;
      fifo_nonempty = (count != '0);
`ifdef FETCH_BYPASS_EN
      bypass        = !fifo_nonempty && (state == BUSY) && valid && instr_ready && !redirect;
`else
      bypass        = 1'b0;
`endif
      // A response is accepted either into the FIFO or straight through the bypass path.
      accept        = (state == BUSY) && valid && !redirect;
      push          = accept && !bypass;
      pop           = fifo_nonempty && instr_ready && !redirect;
      count_next    = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      instr_valid   = (fifo_nonempty || bypass) && !redirect;
      instr_out     = bypass ? instruction : ins_mem[rd_ptr];
      instr_pc      = bypass ? pc : pc_mem[rd_ptr];
      pre_address   = instr_pc + FOUR;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         pc          <= RESET_PC;
         mem_addr    <= RESET_PC;
         mem_request <= 1'b0;
         count       <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
      end else begin
         if (redirect) begin
            pc     <= target;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
         end else begin
            count <= count_next;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
         end

         case (state)
            IDLE: begin
               if (!redirect && !load && (count < FULL)) begin
                  state       <= BUSY;
                  mem_request <= 1'b1;
                  mem_addr    <= pc;
               end
            end
            BUSY: begin
               if (redirect) begin
                  // The in-flight response can't be cancelled; swallow it in DISCARD.
                  if (valid) begin
                     state       <= IDLE;
                     mem_request <= 1'b0;
                  end else begin
                     state <= DISCARD;
                  end
               end else if (valid) begin
                  pc <= pc + FOUR;
                  if ((count_next < FULL) && !load) begin
                     mem_addr <= pc + FOUR;
                  end else begin
                     state       <= IDLE;
                     mem_request <= 1'b0;
                  end
               end
            end
            DISCARD: begin
               if (valid) begin
                  state       <= IDLE;
                  mem_request <= 1'b0;
               end
            end
            default: begin
               state       <= IDLE;
               mem_request <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr]  <= pc;
         ins_mem[wr_ptr] <= instruction;
      end
   end

endmodule
